// File: rtl/alu_pkg.sv
// Shared definitions for the execute controller: opcodes, condition codes,
// instruction field positions, NZCV bit indices and the FSM encoding.
package alu_pkg;

    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int NREG = 8;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_ADC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ORR  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_MVN  = 4'h7;
    localparam logic [3:0] OP_RSB  = 4'h8;
    localparam logic [3:0] OP_LSL  = 4'h9;
    localparam logic [3:0] OP_LSR  = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_MOVI = 4'hC;
    localparam logic [3:0] OP_LDR  = 4'hD;
    localparam logic [3:0] OP_STR  = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam logic [3:0] CC_AL = 4'h0;
    localparam logic [3:0] CC_EQ = 4'h1;
    localparam logic [3:0] CC_NE = 4'h2;
    localparam logic [3:0] CC_CS = 4'h3;
    localparam logic [3:0] CC_CC = 4'h4;
    localparam logic [3:0] CC_MI = 4'h5;
    localparam logic [3:0] CC_PL = 4'h6;
    localparam logic [3:0] CC_VS = 4'h7;
    localparam logic [3:0] CC_VC = 4'h8;
    localparam logic [3:0] CC_HI = 4'h9;
    localparam logic [3:0] CC_LS = 4'hA;
    localparam logic [3:0] CC_GE = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GT = 4'hD;
    localparam logic [3:0] CC_LE = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    localparam int COND_LSB = 28;
    localparam int OP_LSB   = 24;
    localparam int S_BIT    = 23;
    localparam int RD_LSB   = 20;
    localparam int RN_LSB   = 17;
    localparam int RSV_BIT  = 16;
    localparam int IMM_LSB  = 0;
    localparam int RM_LSB   = 0;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Logic ops and moves never touch NZCV; CMP always does.
    function automatic logic op_sets_flags(input logic [3:0] op, input logic s);
        logic arith;
        arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) ||
                (op == OP_RSB) || (op == OP_LSL) || (op == OP_LSR);
        return (op == OP_CMP) || (s && arith);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator: decides whether an instruction with the given
// condition field executes against the current NZCV flags.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            CC_AL: pass = 1'b1;
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Single-issue execute controller: decodes one instruction at a time, drives
// the external combinational ALU or the req/ack memory port, and retires it.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int DW   = 32,
    parameter int AW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    // instr handshake: a word transfers on a cycle with instr_valid && instr_ready
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [31:0]   instr,
    output logic [DW-1:0] alu_src1,
    output logic [DW-1:0] alu_src2,
    output logic [3:0]    alu_op_code,
    output logic [15:0]   alu_imm,
    output logic          alu_s,
    input  logic [DW-1:0] alu_result,
    input  logic [3:0]    alu_flags,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          done,
    output logic          skipped,
    output logic [3:0]    flags,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    state_t        state, state_nx;
    logic [31:0]   instr_q;
    logic [DW-1:0] regs [NREG];
    logic [3:0]    flags_q;
    logic          skipped_q;

    logic [3:0]    cond_f, op_f;
    logic          s_f;
    logic [2:0]    rd_f, rn_f, rm_f;
    logic [15:0]   imm_f;
    logic          cond_pass;

    logic          reg_we;
    logic [DW-1:0] reg_wdata;
    logic          flags_we;
    logic          unused_ok;

    assign cond_f = instr_q[COND_LSB +: 4];
    assign op_f   = instr_q[OP_LSB +: 4];
    assign s_f    = instr_q[S_BIT];
    assign rd_f   = instr_q[RD_LSB +: 3];
    assign rn_f   = instr_q[RN_LSB +: 3];
    assign imm_f  = instr_q[IMM_LSB +: 16];
    assign rm_f   = imm_f[RM_LSB +: 3];

    // The reserved bit carries no meaning.
    assign unused_ok = &{1'b0, instr_q[RSV_BIT]};

    cond_eval u_cond_eval (
        .cond (cond_f),
        .nzcv (flags_q),
        .pass (cond_pass)
    );

    always_comb begin
        state_nx  = state;
        reg_we    = 1'b0;
        reg_wdata = '0;
        flags_we  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (instr_valid) state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                if (!cond_pass) begin
                    state_nx = ST_DONE;
                end else begin
                    case (op_f)
                        OP_NOP:  state_nx = ST_DONE;
                        OP_MOVI: begin
                            reg_we    = 1'b1;
                            reg_wdata = DW'(imm_f);
                            state_nx  = ST_DONE;
                        end
                        OP_LDR, OP_STR: state_nx = ST_MEM;
                        default: state_nx = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                reg_we    = (op_f != OP_CMP);
                reg_wdata = alu_result;
                flags_we  = op_sets_flags(op_f, s_f);
                state_nx  = ST_DONE;
            end
            ST_MEM: begin
                if (mem_ack) begin
                    reg_we    = (op_f == OP_LDR);
                    reg_wdata = mem_rdata;
                    state_nx  = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            instr_q   <= '0;
            flags_q   <= '0;
            skipped_q <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && instr_valid) instr_q <= instr;
            if (state == ST_DECODE) skipped_q <= !cond_pass;
            if (reg_we) regs[rd_f] <= reg_wdata;
            if (flags_we) flags_q <= alu_flags;
        end
    end

    assign instr_ready = (state == ST_IDLE) && !reset;

    // ALU inputs are quiet outside EXEC; LSL shifts R[rn] rather than R[rm].
    always_comb begin
        alu_src1    = '0;
        alu_src2    = '0;
        alu_op_code = '0;
        alu_imm     = '0;
        alu_s       = 1'b0;
        if (state == ST_EXEC) begin
            alu_src1    = regs[rn_f];
            alu_src2    = (op_f == OP_LSL) ? regs[rn_f] : regs[rm_f];
            alu_op_code = op_f;
            alu_imm     = imm_f;
            alu_s       = s_f;
        end
    end

    // Memory outputs derive only from state held constant during MEM.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ST_MEM) begin
            mem_req   = 1'b1;
            mem_we    = (op_f == OP_STR);
            mem_addr  = regs[rn_f][AW-1:0];
            mem_wdata = regs[rd_f];
        end
    end

    assign done     = (state == ST_DONE);
    assign skipped  = (state == ST_DONE) && skipped_q;
    assign flags    = flags_q;
    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small behavioural ALU on the
// alu_* port and hand-driven memory acknowledgements.
module tb_alu_exec_ctrl;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_src1, alu_src2;
    logic [3:0]  alu_op_code;
    logic [15:0] alu_imm;
    logic        alu_s;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        done, skipped;
    logic [3:0]  flags;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    alu_exec_ctrl dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op_code(alu_op_code),
        .alu_imm(alu_imm), .alu_s(alu_s), .alu_result(alu_result), .alu_flags(alu_flags),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .done(done), .skipped(skipped), .flags(flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: logic ops present a fixed stale NZCV of 0101.
    logic [32:0] alu_t;
    always_comb begin
        alu_t      = '0;
        alu_result = '0;
        alu_flags  = 4'b0101;
        case (alu_op_code)
            OP_ADD: begin
                alu_t      = {1'b0, alu_src1} + {1'b0, alu_src2};
                alu_result = alu_t[31:0];
                alu_flags  = {alu_t[31], alu_t[31:0] == 32'd0, alu_t[32],
                              alu_s && (alu_src1[31] == alu_src2[31]) && (alu_t[31] != alu_src1[31])};
            end
            OP_SUB, OP_CMP: begin
                alu_t      = {1'b0, alu_src1} - {1'b0, alu_src2};
                alu_result = alu_t[31:0];
                alu_flags  = {alu_t[31], alu_t[31:0] == 32'd0, !alu_t[32],
                              alu_s && (alu_src1[31] != alu_src2[31]) && (alu_t[31] != alu_src1[31])};
            end
            OP_XOR: alu_result = alu_src1 ^ alu_src2;
            OP_LSL: begin
                alu_result = alu_src2 << alu_imm[7:3];
                alu_flags  = {alu_result[31], alu_result == 32'd0, 2'b00};
            end
            default: alu_result = alu_src1;
        endcase
    end

    typedef struct {
        logic [31:0] iw;
        logic [2:0]  chk_reg;
        logic [31:0] exp_val;
        logic [3:0]  exp_flags;
        logic        exp_skip;
        int          exp_cyc;
        logic        chk_s2;
        logic [31:0] exp_s2;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic logic [31:0] mk(input logic [3:0] c, input logic [3:0] o, input logic sb,
                                       input logic [2:0] rd, input logic [2:0] rn, input logic [15:0] im);
        return {c, o, sb, rd, rn, 1'b0, im};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one instruction and returns at the negedge of the done cycle (or budget).
    task automatic run_instr(input logic [31:0] iw, output int cyc, output logic [31:0] s2);
        @(negedge clk);
        instr       = iw;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = '0;
        cyc = 1;
        s2  = '0;
        while (!done && cyc < 40) begin
            if (cyc == 2) s2 = alu_src2;
            @(negedge clk);
            cyc++;
        end
    endtask

    int          cyc;
    logic [31:0] s2;
    logic [31:0] stored;

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        mem_ack = 1'b0; mem_rdata = '0; dbg_addr = '0; stored = '0;

        vecs[0]  = '{mk(CC_AL, OP_MOVI, 0, 1, 0, 16'h0005), 3'd1, 32'h5,        4'b0000, 1'b0, 2, 1'b0, 32'h0};
        vecs[1]  = '{mk(CC_AL, OP_MOVI, 0, 2, 0, 16'h0003), 3'd2, 32'h3,        4'b0000, 1'b0, 2, 1'b0, 32'h0};
        vecs[2]  = '{mk(CC_AL, OP_ADD,  1, 3, 1, 16'h0002), 3'd3, 32'h8,        4'b0000, 1'b0, 3, 1'b1, 32'h3};
        vecs[3]  = '{mk(CC_AL, OP_MOVI, 0, 1, 0, 16'h0003), 3'd1, 32'h3,        4'b0000, 1'b0, 2, 1'b0, 32'h0};
        vecs[4]  = '{mk(CC_AL, OP_SUB,  1, 3, 1, 16'h0002), 3'd3, 32'h0,        4'b0110, 1'b0, 3, 1'b0, 32'h0};
        vecs[5]  = '{mk(CC_EQ, OP_MOVI, 0, 4, 0, 16'h00AA), 3'd4, 32'hAA,       4'b0110, 1'b0, 2, 1'b0, 32'h0};
        vecs[6]  = '{mk(CC_NE, OP_MOVI, 0, 5, 0, 16'h0077), 3'd5, 32'h0,        4'b0110, 1'b1, 2, 1'b0, 32'h0};
        vecs[7]  = '{mk(CC_AL, OP_XOR,  1, 6, 4, 16'h0002), 3'd6, 32'hA9,       4'b0110, 1'b0, 3, 1'b0, 32'h0};
        vecs[8]  = '{mk(CC_AL, OP_MOVI, 0, 1, 0, 16'h0002), 3'd1, 32'h2,        4'b0110, 1'b0, 2, 1'b0, 32'h0};
        vecs[9]  = '{mk(CC_AL, OP_MOVI, 0, 2, 0, 16'h0005), 3'd2, 32'h5,        4'b0110, 1'b0, 2, 1'b0, 32'h0};
        vecs[10] = '{mk(CC_AL, OP_CMP,  0, 3, 1, 16'h0002), 3'd3, 32'h0,        4'b1000, 1'b0, 3, 1'b1, 32'h5};
        vecs[11] = '{mk(CC_AL, OP_MOVI, 0, 1, 0, 16'h0001), 3'd1, 32'h1,        4'b1000, 1'b0, 2, 1'b0, 32'h0};
        vecs[12] = '{mk(CC_AL, OP_LSL,  0, 5, 1, 16'h0020), 3'd5, 32'h10,       4'b1000, 1'b0, 3, 1'b1, 32'h1};
        vecs[13] = '{mk(CC_AL, OP_NOP,  0, 5, 0, 16'h0000), 3'd5, 32'h10,       4'b1000, 1'b0, 2, 1'b0, 32'h0};
        vecs[14] = '{mk(CC_AL, OP_ADD,  0, 1, 1, 16'h0005), 3'd1, 32'h11,       4'b1000, 1'b0, 3, 1'b1, 32'h10};
        vecs[15] = '{mk(CC_NV, OP_MOVI, 0, 7, 0, 16'h0005), 3'd7, 32'h0,        4'b1000, 1'b1, 2, 1'b0, 32'h0};
        vecs[16] = '{mk(CC_LT, OP_MOVI, 0, 7, 0, 16'h0010), 3'd7, 32'h10,       4'b1000, 1'b0, 2, 1'b0, 32'h0};
        vecs[17] = '{mk(CC_GT, OP_MOVI, 0, 7, 0, 16'h0099), 3'd7, 32'h10,       4'b1000, 1'b1, 2, 1'b0, 32'h0};
        vecs[18] = '{mk(CC_AL, OP_MOVI, 0, 6, 0, 16'h1234), 3'd6, 32'h1234,     4'b1000, 1'b0, 2, 1'b0, 32'h0};
        vecs[19] = '{mk(CC_AL, OP_LSL,  0, 6, 6, 16'h0080), 3'd6, 32'h12340000, 4'b1000, 1'b0, 3, 1'b1, 32'h1234};
        vecs[20] = '{mk(CC_AL, OP_MOVI, 0, 0, 0, 16'h5678), 3'd0, 32'h5678,     4'b1000, 1'b0, 2, 1'b0, 32'h0};
        vecs[21] = '{mk(CC_AL, OP_ADD,  0, 6, 6, 16'h0000), 3'd6, 32'h12345678, 4'b1000, 1'b0, 3, 1'b0, 32'h0};
        vecs[22] = '{mk(CC_AL, OP_MOVI, 0, 2, 0, 16'h8001), 3'd2, 32'h8001,     4'b1000, 1'b0, 2, 1'b0, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst instr_ready", {31'b0, instr_ready}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst flags", {28'b0, flags}, 32'd0);
        chk("rst dbg_data", dbg_data, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle instr_ready", {31'b0, instr_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_instr(vecs[i].iw, cyc, s2);
            chk($sformatf("v%0d done", i), {31'b0, done}, 32'd1);
            chk($sformatf("v%0d cycle", i), cyc, vecs[i].exp_cyc);
            chk($sformatf("v%0d skipped", i), {31'b0, skipped}, {31'b0, vecs[i].exp_skip});
            chk($sformatf("v%0d flags", i), {28'b0, flags}, {28'b0, vecs[i].exp_flags});
            dbg_addr = vecs[i].chk_reg;
            #1;
            chk($sformatf("v%0d R%0d", i, vecs[i].chk_reg), dbg_data, vecs[i].exp_val);
            if (vecs[i].chk_s2) chk($sformatf("v%0d alu_src2", i), s2, vecs[i].exp_s2);
        end

        // Stray ack while idle must be ignored
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray ack done", {31'b0, done}, 32'd0);
        chk("stray ack ready", {31'b0, instr_ready}, 32'd1);

        // STR R6 -> [R7], ack held off for five cycles
        @(negedge clk);
        instr = mk(CC_AL, OP_STR, 0, 6, 7, 16'h0000); instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("str c1 mem_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("str c%0d mem_req", k + 2), {31'b0, mem_req}, 32'd1);
            chk($sformatf("str c%0d mem_we", k + 2), {31'b0, mem_we}, 32'd1);
            chk($sformatf("str c%0d mem_addr", k + 2), {16'b0, mem_addr}, 32'h10);
            chk($sformatf("str c%0d mem_wdata", k + 2), mem_wdata, 32'h12345678);
            if (k == 5) begin
                stored  = mem_wdata;
                mem_ack = 1'b1;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("str done", {31'b0, done}, 32'd1);
        chk("str skipped", {31'b0, skipped}, 32'd0);
        chk("str mem_req drop", {31'b0, mem_req}, 32'd0);
        chk("str alu idle", {28'b0, alu_op_code}, 32'd0);

        // LDR R0 <- [R7], ack at cycle 3
        @(negedge clk);
        instr = mk(CC_AL, OP_LDR, 0, 0, 7, 16'h0000); instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("ldr mem_req", {31'b0, mem_req}, 32'd1);
        chk("ldr mem_we", {31'b0, mem_we}, 32'd0);
        chk("ldr mem_addr", {16'b0, mem_addr}, 32'h10);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = stored;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        chk("ldr done", {31'b0, done}, 32'd1);
        dbg_addr = 3'd0;
        #1;
        chk("ldr R0", dbg_data, 32'h12345678);

        // Reset while a load is outstanding
        @(negedge clk);
        instr = mk(CC_AL, OP_LDR, 0, 1, 7, 16'h0000); instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("mid mem_req", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid rst mem_req", {31'b0, mem_req}, 32'd0);
        chk("mid rst flags", {28'b0, flags}, 32'd0);
        chk("mid rst done", {31'b0, done}, 32'd0);
        chk("mid rst ready", {31'b0, instr_ready}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            chk($sformatf("mid rst R%0d", r), dbg_data, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post rst ready", {31'b0, instr_ready}, 32'd1);

        run_instr(mk(CC_AL, OP_MOVI, 0, 2, 0, 16'h0007), cyc, s2);
        chk("post rst movi done", {31'b0, done}, 32'd1);
        chk("post rst movi cycle", cyc, 32'd2);
        dbg_addr = 3'd2;
        #1;
        chk("post rst R2", dbg_data, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Single-issue execute controller that sequences the team's combinational ALU.
- Accepts one 32-bit instruction per valid/ready handshake.
- Holds an 8x32 register file and the NZCV flags register, and evaluates the condition field against the stored flags.
- Drives the ALU operand, opcode, immediate and s inputs, then writes back the result and, where defined, the flags.
- Handles immediate-load, load/store (through a simple req/ack memory port) and NOP itself, without using the ALU.

Parameters:
NREG, 8, register count; fixed to 8 by the 3-bit register fields.
DW, 32, datapath width.
AW, 16, memory address width; the address is R[rn][AW-1:0].

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept; high only in IDLE
instr  in  32  instruction word
alu_src1  out  32  ALU operand 1
alu_src2  out  32  ALU operand 2
alu_op_code  out  4  ALU opcode
alu_imm  out  16  ALU immediate
alu_s  out  1  ALU signed-overflow enable
alu_result  in  32  ALU result (combinational)
alu_flags  in  4  ALU NZCV (combinational)
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = store
mem_addr  out  16  memory address
mem_wdata  out  32  store data
mem_ack  in  1  one-cycle completion strobe
mem_rdata  in  32  load data, valid with mem_ack
done  out  1  one-cycle pulse per retired instruction
skipped  out  1  qualifies done: condition failed, no state change
flags  out  4  architectural NZCV
dbg_addr  in  3  debug register select
dbg_data  out  32  R[dbg_addr], combinational read

Behaviour:
Instruction fields:
- cond[31:28], op[27:24], s[23], rd[22:20], rn[19:17], bit16 reserved (ignored), imm[15:0].
- rm = imm[2:0].

Operand routing in EXEC:
- alu_src1 = R[rn] and alu_src2 = R[rm], except op 1001, where alu_src2 = R[rn].
- alu_imm = imm, alu_op_code = op, alu_s = s.
- Outside EXEC, all alu_* outputs are 0.

Opcode classes:
- ALU ops 0000–1011.
- 1100: R[rd] = zero-extended imm; no ALU.
- 1101 (LDR): R[rd] = MEM[R[rn]].
- 1110 (STR): MEM[R[rn]] = R[rd].
- 1111: NOP.

Conditions, evaluated on the flags register in DECODE:
- 0000 AL, 0001 EQ (Z), 0010 NE, 0011 CS (C), 0100 CC, 0101 MI (N), 0110 PL, 0111 VS (V), 1000 VC.
- 1001 HI (C & !Z), 1010 LS, 1011 GE (N==V), 1100 LT, 1101 GT (!Z & N==V), 1110 LE, 1111 NV (never).

FSM states: IDLE, DECODE, EXEC, MEM, DONE.
- IDLE: instr_ready=1. On instr_valid, latch instr and go to DECODE (cycle 0 = handshake cycle).
- DECODE: condition false -> DONE with skipped=1. Op 1111 -> DONE. Op 1100 -> write R[rd] and go to DONE. Ops 1101/1110 -> MEM. Otherwise -> EXEC.
- EXEC (one cycle): capture alu_result into R[rd], except op 1011 (CMP), which does no register write.
  - Flags register <= alu_flags only for op 1011, or for ops {0000, 0001, 0010, 1000, 1001, 1010} with s=1.
  - Logic ops and moves never update flags (the ALU holds stale NZCV for them).
  - Go to DONE.
- MEM: mem_req=1, mem_addr=R[rn][15:0], mem_we=(op==1110), mem_wdata=R[rd].
  - Hold all mem_* outputs stable until mem_ack; there is no timeout.
  - On ack, a load writes R[rd] = mem_rdata; go to DONE.
  - mem_ack outside MEM is ignored.
- DONE: done=1 and skipped as decided; return to IDLE.

Latency:
- ALU op: done at cycle 3.
- Condition-fail, NOP and 1100: done at cycle 2.
- Memory op: done 1 cycle after the ack cycle.
- Minimum issue interval: 4 cycles for ALU ops.

Other rules:
- Register writes are visible on dbg_data in the DONE cycle. rd==rn is legal; the source is read before the write.
- Reset, including mid-operation: state -> IDLE; all registers, flags, done, skipped and mem_req -> 0 on the next edge. An outstanding memory transaction is abandoned.
- Reset values: instr_ready=0 during reset and 1 in the first IDLE cycle; all other outputs 0.
- Unknown or reserved encodings do not exist; every op is defined.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD..OP_NOP);
  - condition-code localparams;
  - instruction field bit positions;
  - FSM state encoding;
  - NZCV bit indices (N=3, Z=2, C=1, V=0).
- One natural sub-module, cond_eval: combinational (cond, NZCV) -> pass. Reusable by a future branch unit.
- The register file stays inline.

Test Plan:
- Reset, then R1=5, R2=3 via op 1100; ADD s=1, rd=3, rn=1, rm=2 -> R3=8, flags 0000, done at cycle 3, skipped=0.
- SUB s=1, R1=3, R2=3 -> result 0, flags Z=1. Then EQ-conditioned MOVI rd=4, imm=0x00AA -> R4=0xAA. Then NE-conditioned MOVI rd=5 -> done with skipped=1, R5 unchanged.
- XOR with s=1 after a flag-setting SUB -> flags unchanged. CMP R1=2, R2=5 -> no register write, N=1.
- STR R6=0x1234_5678 to address R7=0x0010, ack delayed 5 cycles -> mem_req held stable for 6 cycles, mem_we=1. Then LDR rd=0 returning 0x1234_5678 -> R0 matches, done 1 cycle after ack.
- LSL (op 1001) rn=1 holding 1, imm[7:3]=4 -> alu_src2=R1, R[rd]=16. Op 1111 -> done at cycle 2, no state change.
- Assert reset while in MEM with mem_req=1 -> next cycle mem_req=0, flags=0, all registers 0, instr_ready=1 after reset deasserts.
